// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX data source.
// Holds the offer FSM state encoding and the ASCII hex-digit conversion.
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE,
        OFFER
    } tx_src_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    function automatic logic [7:0] to_ascii_hex(input logic [3:0] v);
        return (v < 4'd10) ? ASCII_ZERO + 8'(v) : ASCII_A + 8'(v - 4'd10);
    endfunction

endpackage

// File: rtl/uart_sync_debounce.sv
// Multi-bit synchroniser followed by a stability counter; commits a new value
// after DEBOUNCE_CYCLES stable cycles and flags the commit with a change pulse.
module uart_sync_debounce
#(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] candidate,
    output logic [WIDTH-1:0] stable_value,
    output logic             change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sync_sw;

    assign sync_sw = sync_q[SYNC_STAGES-1];

    // Combinational so the commit and the downstream offer land on the same edge.
    assign change = (cnt == CNT_MAX) && (candidate != stable_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchroniser array is small flop storage, so every stage is reset explicitly.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            candidate    <= '0;
            cnt          <= '0;
            stable_value <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

            if (sync_sw != candidate) begin
                candidate <= sync_sw;
                cnt       <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (change) stable_value <= candidate;
        end
    end

endmodule

// File: rtl/uart_tx_data_source.sv
// Debounced switch / send-button byte source feeding the UART TX over valid/ready.
// Define UART_TX_ASCII_EN to offer the ASCII hex digit instead of the raw value.
module uart_tx_data_source
    import uart_pkg::*;
#(
    parameter int SW_WIDTH        = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  send_btn,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] data_parallel,
    output logic [SW_WIDTH-1:0]   stable_value,
    output logic                  overrun
);

    logic [SW_WIDTH-1:0]    candidate;
    logic                   change;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   sync_btn_d;
    logic                   send_edge;
    logic                   event_fire;
    logic [SW_WIDTH-1:0]    commit_value;
    logic [DATA_WIDTH-1:0]  next_byte;
    tx_src_state_t          state;

    uart_sync_debounce #(
        .WIDTH           (SW_WIDTH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk          (Clk),
        .rst_n        (Rst_n),
        .raw          (switches),
        .candidate    (candidate),
        .stable_value (stable_value),
        .change       (change)
    );

    // Button path: plain synchroniser, delay flop, and a registered rising-edge pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            btn_sync   <= '0;
            sync_btn_d <= 1'b0;
            send_edge  <= 1'b0;
        end else begin
            btn_sync   <= {btn_sync[SYNC_STAGES-2:0], send_btn};
            sync_btn_d <= btn_sync[SYNC_STAGES-1];
            send_edge  <= btn_sync[SYNC_STAGES-1] & ~sync_btn_d;
        end
    end

    assign event_fire   = change | send_edge;
    // On a commit the stable register has not updated yet, so take the candidate.
    assign commit_value = change ? candidate : stable_value;

`ifdef UART_TX_ASCII_EN
    assign next_byte = DATA_WIDTH'(to_ascii_hex(4'(commit_value)));
`else
    assign next_byte = DATA_WIDTH'(commit_value);
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            tx_valid      <= 1'b0;
            data_parallel <= '0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (event_fire) begin
                        state         <= OFFER;
                        tx_valid      <= 1'b1;
                        data_parallel <= next_byte;
                    end
                end
                OFFER: begin
                    if (event_fire) begin
                        // Latest value wins; replacing an untransferred byte is an overrun.
                        data_parallel <= next_byte;
                        overrun       <= ~tx_ready;
                    end else if (tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_data_source.sv
// Scoreboard bench for uart_tx_data_source: expected bytes are queued by the
// stimulus process and popped by a monitor on every valid/ready transfer.
module tb_uart_tx_data_source;

`ifdef UART_TX_ASCII_EN
    localparam logic [7:0] B00 = 8'h30;
    localparam logic [7:0] B02 = 8'h32;
    localparam logic [7:0] B05 = 8'h35;
    localparam logic [7:0] B06 = 8'h36;
    localparam logic [7:0] B07 = 8'h37;
`else
    localparam logic [7:0] B00 = 8'h00;
    localparam logic [7:0] B02 = 8'h02;
    localparam logic [7:0] B05 = 8'h05;
    localparam logic [7:0] B06 = 8'h06;
    localparam logic [7:0] B07 = 8'h07;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [2:0] switches = 3'b000;
    logic       send_btn = 1'b0;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] data_parallel;
    logic [2:0] stable_value;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int overrun_seen = 0;
    int valid_seen = 0;
    logic [7:0] exp_q [$];

    uart_tx_data_source #(
        .SW_WIDTH        (3),
        .DATA_WIDTH      (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .switches      (switches),
        .send_btn      (send_btn),
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .data_parallel (data_parallel),
        .stable_value  (stable_value),
        .overrun       (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change on the falling edge, so sample 1 time unit later.
    always begin
        @(negedge Clk);
        #1;
        if (Rst_n) begin
            if (overrun) overrun_seen++;
            if (tx_valid) valid_seen++;
            if (tx_valid && tx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL transfer: unexpected byte %0h, scoreboard empty", data_parallel);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_parallel !== e) begin
                        fails++;
                        $display("FAIL transfer: got %0h, expected %0h", data_parallel, e);
                    end
                end
            end
        end
    end

    // Counts rising edges from the drive point until tx_valid is seen high.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(posedge Clk);
            n++;
            #1;
        end while (!tx_valid && n <= budget);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge Clk);
    endtask

    initial begin
        int n;
        int base;

        // 1: reset state and quiet idle
        #12;
        check("reset_valid", tx_valid, 1'b0);
        check("reset_data", data_parallel, 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle(100);
        check("idle_no_valid", valid_seen, 0);
        check("idle_data", data_parallel, 8'h00);
        check("idle_stable", stable_value, 3'b000);

        // 2: 000 -> 101, 19-cycle latency, one-cycle offer
        exp_q.push_back(B05);
        switches = 3'b101;
        wait_valid(40, n);
        check("sw_latency", n, 19);
        check("sw_stable", stable_value, 3'b101);
        @(posedge Clk); #1;
        check("sw_one_cycle", tx_valid, 1'b0);
        idle(5);
        exp_q.push_back(B00);
        switches = 3'b000;
        idle(30);

        // 3: short glitch is rejected
        base = valid_seen;
        switches = 3'b011;
        idle(10);
        switches = 3'b000;
        idle(40);
        check("glitch_stable", stable_value, 3'b000);
        check("glitch_no_valid", valid_seen - base, 0);

        // 4: overrun while TX is stalled, latest value wins
        tx_ready = 1'b0;
        base = overrun_seen;
        switches = 3'b010;
        wait_valid(40, n);
        check("stall_latency", n, 19);
        check("stall_first", data_parallel, B02);
        idle(3);
        switches = 3'b111;
        n = 0;
        while (data_parallel !== B07 && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        check("stall_replace_latency", n, 19);
        idle(5);
        check("overrun_once", overrun_seen - base, 1);
        check("stall_held", tx_valid, 1'b1);
        exp_q.push_back(B07);
        tx_ready = 1'b1;
        idle(3);
        check("stall_drained", tx_valid, 1'b0);

        // 5: three send-button presses on a settled 110
        exp_q.push_back(B06);
        switches = 3'b110;
        idle(30);
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back(B06);
            send_btn = 1'b1;
            wait_valid(10, n);
            check("btn_latency", n, 4);
            idle(6);
            send_btn = 1'b0;
            idle(19);
        end

        // 6: reset while an offer is stalled drops it
        exp_q.push_back(B00);
        switches = 3'b000;
        idle(30);
        tx_ready = 1'b0;
        send_btn = 1'b1;
        wait_valid(10, n);
        check("pre_reset_latency", n, 4);
        @(negedge Clk);
        send_btn = 1'b0;
        idle(4);
        check("pre_reset_held", tx_valid, 1'b1);
        #3;
        Rst_n = 1'b0;
        #1;
        check("async_reset_valid", tx_valid, 1'b0);
        check("async_reset_stable", stable_value, 3'b000);
        idle(2);
        Rst_n = 1'b1;
        tx_ready = 1'b1;
        base = valid_seen;
        idle(100);
        check("post_reset_quiet", valid_seen - base, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
